// File: rtl/rob_recovery_ctrl.sv
// Branch-mispredict recovery sequencer for the reorder buffer: walks younger
// entries youngest-first, restores the ROB tail, then issues one fetch redirect.
module rob_recovery_ctrl #(
    parameter int PTR_WIDTH  = 4,
    parameter int ADDR_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  mispredict_valid,
    input  logic [PTR_WIDTH-1:0]  mispredict_idx,
    input  logic [ADDR_WIDTH-1:0] mispredict_target,
    input  logic [PTR_WIDTH-1:0]  rob_head,
    input  logic [PTR_WIDTH-1:0]  rob_tail,
    output logic                  busy,
    output logic                  stall_frontend,
    output logic                  squash_valid,
    output logic [PTR_WIDTH-1:0]  squash_idx,
    output logic                  tail_restore_valid,
    output logic [PTR_WIDTH-1:0]  tail_restore_ptr,
    output logic                  redirect_valid,
    output logic [ADDR_WIDTH-1:0] redirect_pc
);

    typedef enum logic [1:0] {
        S_IDLE     = 2'd0,
        S_WALK     = 2'd1,
        S_RESTORE  = 2'd2,
        S_REDIRECT = 2'd3
    } state_e;

    localparam logic [PTR_WIDTH-1:0] PTR_ONE = PTR_WIDTH'(1);

    state_e                 state_q, state_d;
    logic [PTR_WIDTH-1:0]   walk_ptr_q, walk_ptr_d;
    logic [PTR_WIDTH-1:0]   br_idx_q, br_idx_d;
    logic [ADDR_WIDTH-1:0]  br_target_q, br_target_d;

    logic                   busy_q;
    logic                   squash_valid_q;
    logic [PTR_WIDTH-1:0]   squash_idx_q;
    logic                   tail_restore_valid_q;
    logic [PTR_WIDTH-1:0]   tail_restore_ptr_q;
    logic                   redirect_valid_q;
    logic [ADDR_WIDTH-1:0]  redirect_pc_q;

    logic [PTR_WIDTH-1:0]   mp_age;
    logic [PTR_WIDTH-1:0]   br_age;
    logic [PTR_WIDTH-1:0]   tail_m1;
    logic [PTR_WIDTH-1:0]   br_p1;
    logic [PTR_WIDTH-1:0]   br_d_p1;
    logic                   older_mp;

    // Ages are distances from the live head, so commit during recovery is tolerated.
    always_comb begin
        mp_age   = mispredict_idx - rob_head;
        br_age   = br_idx_q - rob_head;
        older_mp = mispredict_valid && (mp_age < br_age);
        tail_m1  = rob_tail - PTR_ONE;
        br_p1    = br_idx_q + PTR_ONE;
    end

    always_comb begin
        state_d     = state_q;
        walk_ptr_d  = walk_ptr_q;
        br_idx_d    = br_idx_q;
        br_target_d = br_target_q;

        case (state_q)
            S_IDLE: begin
                if (mispredict_valid) begin
                    br_idx_d    = mispredict_idx;
                    br_target_d = mispredict_target;
                    walk_ptr_d  = tail_m1;
                    state_d     = (tail_m1 == mispredict_idx) ? S_RESTORE : S_WALK;
                end
            end
            S_WALK: begin
                // An older branch only extends the walk; the next stop test sees it.
                if (older_mp) begin
                    br_idx_d    = mispredict_idx;
                    br_target_d = mispredict_target;
                    walk_ptr_d  = walk_ptr_q - PTR_ONE;
                end else if (walk_ptr_q == br_p1) begin
                    state_d = S_RESTORE;
                end else begin
                    walk_ptr_d = walk_ptr_q - PTR_ONE;
                end
            end
            S_RESTORE, S_REDIRECT: begin
                // Re-enter the walk at the old branch, which is now younger than the new one.
                if (older_mp) begin
                    br_idx_d    = mispredict_idx;
                    br_target_d = mispredict_target;
                    walk_ptr_d  = br_idx_q;
                    state_d     = S_WALK;
                end else begin
                    state_d = (state_q == S_RESTORE) ? S_REDIRECT : S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        br_d_p1 = br_idx_d + PTR_ONE;
    end

    // Outputs are registered from the next-state values so they align with the state.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q              <= S_IDLE;
            walk_ptr_q           <= '0;
            br_idx_q             <= '0;
            br_target_q          <= '0;
            busy_q               <= 1'b0;
            squash_valid_q       <= 1'b0;
            squash_idx_q         <= '0;
            tail_restore_valid_q <= 1'b0;
            tail_restore_ptr_q   <= '0;
            redirect_valid_q     <= 1'b0;
            redirect_pc_q        <= '0;
        end else begin
            state_q              <= state_d;
            walk_ptr_q           <= walk_ptr_d;
            br_idx_q             <= br_idx_d;
            br_target_q          <= br_target_d;
            busy_q               <= (state_d != S_IDLE);
            squash_valid_q       <= (state_d == S_WALK);
            squash_idx_q         <= (state_d == S_WALK) ? walk_ptr_d : '0;
            tail_restore_valid_q <= (state_d == S_RESTORE);
            tail_restore_ptr_q   <= (state_d == S_RESTORE) ? br_d_p1 : '0;
            redirect_valid_q     <= (state_d == S_REDIRECT);
            redirect_pc_q        <= (state_d == S_REDIRECT) ? br_target_d : '0;
        end
    end

    assign busy               = busy_q;
    assign stall_frontend     = busy_q;
    assign squash_valid       = squash_valid_q;
    assign squash_idx         = squash_idx_q;
    assign tail_restore_valid = tail_restore_valid_q;
    assign tail_restore_ptr   = tail_restore_ptr_q;
    assign redirect_valid     = redirect_valid_q;
    assign redirect_pc        = redirect_pc_q;

endmodule

// File: tb/tb_rob_recovery_ctrl.sv
// Scoreboard bench for rob_recovery_ctrl: an action-list recovery model feeds
// an expected-output queue that a negedge monitor drains against the DUT.
module tb_rob_recovery_ctrl;

    localparam int PW = 4;
    localparam int AW = 32;

    typedef enum logic [1:0] {A_SQ = 2'd0, A_RS = 2'd1, A_RD = 2'd2} kind_e;
    typedef struct {
        kind_e         kind;
        logic [AW-1:0] val;
    } act_t;

    logic          clk = 1'b0;
    logic          reset;
    logic          mispredict_valid;
    logic [PW-1:0] mispredict_idx;
    logic [AW-1:0] mispredict_target;
    logic [PW-1:0] rob_head;
    logic [PW-1:0] rob_tail;
    logic          busy;
    logic          stall_frontend;
    logic          squash_valid;
    logic [PW-1:0] squash_idx;
    logic          tail_restore_valid;
    logic [PW-1:0] tail_restore_ptr;
    logic          redirect_valid;
    logic [AW-1:0] redirect_pc;

    rob_recovery_ctrl #(.PTR_WIDTH(PW), .ADDR_WIDTH(AW)) dut (
        .clk                (clk),
        .reset              (reset),
        .mispredict_valid   (mispredict_valid),
        .mispredict_idx     (mispredict_idx),
        .mispredict_target  (mispredict_target),
        .rob_head           (rob_head),
        .rob_tail           (rob_tail),
        .busy               (busy),
        .stall_frontend     (stall_frontend),
        .squash_valid       (squash_valid),
        .squash_idx         (squash_idx),
        .tail_restore_valid (tail_restore_valid),
        .tail_restore_ptr   (tail_restore_ptr),
        .redirect_valid     (redirect_valid),
        .redirect_pc        (redirect_pc)
    );

    always #5 clk = ~clk;

    act_t          pend[$];
    act_t          exp_q[$];
    act_t          cur;
    bit            cur_v;
    logic [PW-1:0] br_m;
    int            n_checks;
    int            n_fail;
    int            busy_cycles;

    logic [PW-1:0] h, idx, span;
    int            cnt;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, got, exp);
        end
    endtask

    function automatic int age(input logic [PW-1:0] x);
        logic [PW-1:0] d;
        d = x - rob_head;
        return int'(d);
    endfunction

    function automatic act_t mk(input kind_e k, input logic [AW-1:0] v);
        act_t a;
        a.kind = k;
        a.val  = v;
        return a;
    endfunction

    // Remaining recovery: squash start down to idx+1, then restore and redirect.
    task automatic build(input logic [PW-1:0] start, input logic [PW-1:0] bidx,
                         input logic [AW-1:0] tgt);
        logic [PW-1:0] w;
        logic [PW-1:0] rp;
        pend.delete();
        w = start;
        while (w != bidx) begin
            pend.push_back(mk(A_SQ, {{(AW-PW){1'b0}}, w}));
            w = w - 1'b1;
        end
        rp = bidx + 1'b1;
        pend.push_back(mk(A_RS, {{(AW-PW){1'b0}}, rp}));
        pend.push_back(mk(A_RD, tgt));
        br_m = bidx;
    endtask

    task automatic model_edge(input bit mv, input logic [PW-1:0] i, input logic [AW-1:0] tgt);
        logic [PW-1:0] st;
        if (mv) begin
            if (!cur_v) begin
                build(rob_tail - 1'b1, i, tgt);
            end else if (age(i) < age(br_m)) begin
                st = cur.val[PW-1:0] - 1'b1;
                build((cur.kind == A_SQ) ? st : br_m, i, tgt);
            end
        end
        if (pend.size() > 0) begin
            cur   = pend.pop_front();
            cur_v = 1'b1;
            exp_q.push_back(cur);
        end else begin
            cur_v = 1'b0;
        end
    endtask

    task automatic step(input bit mv, input logic [PW-1:0] i, input logic [AW-1:0] tgt);
        mispredict_valid  = mv;
        mispredict_idx    = i;
        mispredict_target = tgt;
        @(posedge clk);
        model_edge(mv, i, tgt);
        #1;
        mispredict_valid = 1'b0;
    endtask

    task automatic drain();
        for (int i = 0; i < 64 && cur_v; i++) step(1'b0, '0, '0);
        chk("drain_timeout", 32'(cur_v), 0);
        step(1'b0, '0, '0);
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, "_busy"}, 32'(busy), 0);
        chk({tag, "_stall"}, 32'(stall_frontend), 0);
        chk({tag, "_sq_v"}, 32'(squash_valid), 0);
        chk({tag, "_sq_idx"}, 32'(squash_idx), 0);
        chk({tag, "_rs_v"}, 32'(tail_restore_valid), 0);
        chk({tag, "_rs_ptr"}, 32'(tail_restore_ptr), 0);
        chk({tag, "_rd_v"}, 32'(redirect_valid), 0);
        chk({tag, "_rd_pc"}, redirect_pc, 0);
    endtask

    // Monitor: pop one expected action whenever the DUT presents one.
    int            nact;
    act_t          got_a;
    act_t          exp_a;
    always @(negedge clk) begin
        if (!reset) begin
            nact = int'(squash_valid) + int'(tail_restore_valid) + int'(redirect_valid);
            chk("stall_eq_busy", 32'(stall_frontend), 32'(busy));
            chk("one_action_when_busy", 32'(nact == 1), 32'(busy));
            if (busy) busy_cycles++;
            if (nact != 0) begin
                if (squash_valid)            got_a = mk(A_SQ, {{(AW-PW){1'b0}}, squash_idx});
                else if (tail_restore_valid) got_a = mk(A_RS, {{(AW-PW){1'b0}}, tail_restore_ptr});
                else                         got_a = mk(A_RD, redirect_pc);
                if (exp_q.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL unexpected_action: got kind %0d val %0h, expected none",
                             int'(got_a.kind), got_a.val);
                end else begin
                    exp_a = exp_q.pop_front();
                    $display("t=%0t action kind=%0d val=%0h (exp kind=%0d val=%0h)",
                             $time, int'(got_a.kind), got_a.val, int'(exp_a.kind), exp_a.val);
                    chk("action_kind", 32'(got_a.kind), 32'(exp_a.kind));
                    chk("action_val", got_a.val, exp_a.val);
                end
            end else if (exp_q.size() != 0) begin
                exp_a = exp_q.pop_front();
                n_checks++;
                n_fail++;
                $display("FAIL missing_action: got none, expected kind %0d val %0h",
                         int'(exp_a.kind), exp_a.val);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: got no finish, expected finish");
        $fatal(1, "timeout");
    end

    initial begin
        n_checks = 0; n_fail = 0; busy_cycles = 0;
        cur_v = 1'b0; br_m = '0;
        reset = 1'b1;
        mispredict_valid = 1'b0; mispredict_idx = '0; mispredict_target = '0;
        rob_head = '0; rob_tail = '0;
        #1;
        chk_zero("reset");
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
        step(1'b0, '0, '0);

        // Basic: squash 5,4,3; restore 3; redirect 0x100
        rob_head = 4'd0; rob_tail = 4'd6; busy_cycles = 0;
        step(1'b1, 4'd2, 32'h100);
        drain();
        chk("latency_basic", 32'(busy_cycles), 5);

        // No younger entries
        rob_head = 4'd0; rob_tail = 4'd3; busy_cycles = 0;
        step(1'b1, 4'd2, 32'h120);
        drain();
        chk("latency_no_younger", 32'(busy_cycles), 2);

        // Wrap-around: squash 1,0; restore 0
        rob_head = 4'd14; rob_tail = 4'd2; busy_cycles = 0;
        step(1'b1, 4'd15, 32'h140);
        drain();
        chk("latency_wrap", 32'(busy_cycles), 4);

        // Full ROB: 15 squashes
        rob_head = 4'd5; rob_tail = 4'd5; busy_cycles = 0;
        step(1'b1, 4'd5, 32'h160);
        drain();
        chk("latency_full", 32'(busy_cycles), 17);

        // Older mispredict during WALK, later younger one ignored
        rob_head = 4'd0; rob_tail = 4'd10; busy_cycles = 0;
        step(1'b1, 4'd7, 32'h180);
        step(1'b1, 4'd4, 32'h200);
        step(1'b0, '0, '0);
        step(1'b1, 4'd8, 32'h300);
        drain();
        chk("latency_walk_supersede", 32'(busy_cycles), 7);

        // Older mispredict during RESTORE
        rob_head = 4'd0; rob_tail = 4'd3; busy_cycles = 0;
        step(1'b1, 4'd2, 32'h220);
        step(1'b1, 4'd1, 32'h240);
        drain();
        chk("latency_restore_supersede", 32'(busy_cycles), 4);

        // Reset mid-walk aborts at once and stays idle afterwards
        rob_head = 4'd0; rob_tail = 4'd10;
        step(1'b1, 4'd1, 32'h260);
        step(1'b0, '0, '0);
        reset = 1'b1;
        pend.delete(); exp_q.delete(); cur_v = 1'b0;
        #1;
        chk_zero("midwalk_reset");
        @(posedge clk);
        #1 reset = 1'b0;
        repeat (3) step(1'b0, '0, '0);

        // Randomized recoveries with commits and overlapping mispredicts
        for (int t = 0; t < 60; t++) begin
            h = 4'($urandom);
            cnt = $urandom_range(1, 16);
            rob_head = h;
            rob_tail = h + 4'(cnt);
            idx = h + 4'($urandom_range(0, cnt - 1));
            step(1'b1, idx, $urandom);
            for (int c = 0; c < 64 && cur_v; c++) begin
                if ($urandom_range(0, 3) == 0 && rob_head != br_m) rob_head = rob_head + 1'b1;
                span = rob_tail - 1'b1 - rob_head;
                if ($urandom_range(0, 4) == 0)
                    step(1'b1, rob_head + 4'($urandom_range(0, int'(span))), $urandom);
                else
                    step(1'b0, '0, '0);
            end
            chk("random_timeout", 32'(cur_v), 0);
            if ($urandom_range(0, 1) == 1) step(1'b0, '0, '0);
        end
        step(1'b0, '0, '0);
        step(1'b0, '0, '0);
        chk("scoreboard_empty", 32'(exp_q.size()), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/rob_recovery_ctrl.md
# rob_recovery_ctrl

Sequences reorder-buffer recovery after a branch mispredict. On a mispredict it stalls the front end and squashes every younger ROB entry one per cycle, youngest first, so rename and free-list state unwinds in reverse order. It then restores the ROB tail to the slot after the branch and issues a single redirect to the correct PC. It sits between the branch execution unit and the ROB / rename / fetch control.

## Interface
Parameters:
- PTR_WIDTH, 4, ROB index width; ROB depth = 2^PTR_WIDTH
- ADDR_WIDTH, 32, PC width

Ports:
- clk  in  1  clock
- reset  in  1  asynchronous, active-high
- mispredict_valid  in  1  one-cycle pulse from branch unit
- mispredict_idx  in  PTR_WIDTH  ROB index of the mispredicted branch; caller guarantees it lies in [rob_head, rob_tail)
- mispredict_target  in  ADDR_WIDTH  correct fetch PC
- rob_head  in  PTR_WIDTH  oldest valid entry
- rob_tail  in  PTR_WIDTH  next free slot
- busy  out  1  controller not in IDLE
- stall_frontend  out  1  block fetch/dispatch
- squash_valid  out  1  squash entry squash_idx this cycle
- squash_idx  out  PTR_WIDTH  entry being squashed
- tail_restore_valid  out  1  one-cycle pulse: ROB sets tail to tail_restore_ptr
- tail_restore_ptr  out  PTR_WIDTH  branch idx + 1 (mod depth)
- redirect_valid  out  1  one-cycle pulse to fetch
- redirect_pc  out  ADDR_WIDTH  latched mispredict_target

## Operation
- States: IDLE, WALK, RESTORE, REDIRECT. All outputs are decoded from registered state and registered latches only; no input-to-output combinational path.
- IDLE, mispredict_valid=1:
  - Latch br_idx = mispredict_idx and br_target = mispredict_target; set walk_ptr = rob_tail - 1 (mod depth).
  - If rob_tail - 1 == mispredict_idx (no younger entries), go to RESTORE; else go to WALK.
- WALK:
  - Outputs: squash_valid=1, squash_idx=walk_ptr.
  - If walk_ptr == br_idx + 1, go to RESTORE; else decrement walk_ptr (mod depth).
- RESTORE: tail_restore_valid=1, tail_restore_ptr=br_idx+1; go to REDIRECT.
- REDIRECT: redirect_valid=1, redirect_pc=br_target; go to IDLE.
- busy and stall_frontend are 1 in every state except IDLE.
- Age compare: age(x) = (x - rob_head) mod 2^PTR_WIDTH. A mispredict is "older" when age(mispredict_idx) < age(br_idx).
- mispredict_valid while busy:
  - Older: re-latch br_idx and br_target.
    - In WALK: walk_ptr still decrements normally, and the stop test on the next cycle uses the new br_idx.
    - In RESTORE or REDIRECT: set walk_ptr = old br_idx and go to WALK. The current cycle's pulse is still emitted; the later restore and redirect supersede it.
  - Same or younger: ignored.
- All pointer arithmetic is modulo 2^PTR_WIDTH; wrap-around is legal everywhere.
- Full ROB (rob_tail == rob_head with all slots valid) needs no special case: the walk starts at rob_tail - 1.

## Timing
- Reset (async): state=IDLE, walk_ptr/br_idx/br_target=0. Every output is 0, including squash_idx, tail_restore_ptr and redirect_pc.
- Mispredict sampled at edge 0, with N younger entries:
  - squash pulses in cycles 1..N
  - tail restore in cycle N+1
  - redirect in cycle N+2
  - IDLE (busy=0) in cycle N+3
- stall_frontend is high in cycles 1..N+2. Total recovery latency is N+2 cycles.
- Exactly one squash per cycle, strictly youngest to oldest. The branch entry itself is never squashed unless a later, older mispredict supersedes it.
- rob_head/rob_tail are sampled only on the accepting edge. Commit may advance rob_head during recovery; the age compare uses the live rob_head.
- Reset asserted mid-recovery aborts immediately. No further pulses are emitted after reset is released until a new mispredict arrives.

## Test plan
- head=0, tail=6, mispredict idx=2, target=0x100 -> squash 5,4,3 in cycles 1-3; restore ptr=3 in cycle 4; redirect 0x100 in cycle 5; busy=0 in cycle 6.
- head=0, tail=3, idx=2 -> no squash; restore ptr=3 in cycle 1; redirect in cycle 2; stall high for exactly 2 cycles.
- Wrap: head=14, tail=2, idx=15 (PTR_WIDTH=4) -> squash 1,0; restore ptr=0; redirect.
- head=0, tail=10, idx=7, target=0x180; in cycle 1 (squashing 9) mispredict idx=4, target=0x200; in cycle 3 mispredict idx=8 -> squash 9,8,7,6,5; restore ptr=5; single redirect 0x200; the idx=8 event is ignored.
- idx=2 accepted, then in the RESTORE cycle an older mispredict idx=1 -> restore 3 emitted, then squash 2, restore 2, redirect to the new target.
- Reset asserted during WALK -> all outputs 0 in the same cycle; busy stays 0 after release with no mispredict.
